// File: rtl/cic_pkg.sv
// Shared CIC decimator constants: parameter limits and accumulator width rule.
// Benches import this so they derive ACC_W the same way the filter does.
package cic_pkg;

    localparam int N_MIN = 1;
    localparam int N_MAX = 6;
    localparam int R_MIN = 2;
    localparam int R_MAX = 64;
    localparam int M_MIN = 1;
    localparam int M_MAX = 2;

    // Hogenauer growth: N * log2(R*M) bits above the input width.
    function automatic int acc_width(int in_w, int n, int r, int m);
        return in_w + n * $clog2(r * m);
    endfunction

    function automatic bit cfg_ok(int n, int r, int m, int out_w, int acc_w);
        return (n >= N_MIN) && (n <= N_MAX) &&
               (r >= R_MIN) && (r <= R_MAX) &&
               (m >= M_MIN) && (m <= M_MAX) &&
               (out_w >= 1) && (out_w <= acc_w);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x delayed M strobes, one output register.
// Advances only on its strobe; strobe_o is the strobe delayed by one cycle.
module cic_comb_stage #(
    parameter int W = 22,
    parameter int M = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] data_i,
    input  logic         strobe_i,
    output logic [W-1:0] data_o,
    output logic         strobe_o
);

    logic [M-1:0][W-1:0] dly_q;
    logic [W-1:0]        out_q;
    logic [W-1:0]        out_d;
    logic                stb_q;

    assign out_d = data_i - dly_q[M-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            dly_q <= '0;
            out_q <= '0;
            stb_q <= 1'b0;
        end else begin
            stb_q <= strobe_i;
            if (strobe_i) begin
                out_q    <= out_d;
                dly_q[0] <= data_i;
                for (int i = 1; i < M; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
    end

    assign data_o   = out_q;
    assign strobe_o = stb_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: inline integrators, decimate-by-RATE capture, comb pipeline.
// Define CIC_DECIM_ROUND_EN for round-half-up output (one extra cycle of latency).
module cic_decimator
    import cic_pkg::*;
#(
    parameter  int N_STAGES   = 3,
    parameter  int RATE       = 4,
    parameter  int DIFF_DELAY = 1,
    parameter  int IN_W       = 16,
    parameter  int OUT_W      = 16,
    localparam int ACC_W      = acc_width(IN_W, N_STAGES, RATE, DIFF_DELAY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  x_in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] y_out,
    output logic             out_valid
);

    localparam int PH_W = $clog2(RATE);

    if (!cfg_ok(N_STAGES, RATE, DIFF_DELAY, OUT_W, ACC_W)) begin : g_bad_cfg
        $error("cic_decimator: parameter out of range");
    end

    logic [PH_W-1:0]                 phase_q, phase_d;
    logic                            strobe_q, strobe_d;
    logic [ACC_W-1:0]                x_ext;
    logic [N_STAGES-1:0][ACC_W-1:0]  integ_q, integ_d;
    logic [ACC_W-1:0]                samp_q;
    logic                            samp_v_q;

    assign x_ext = {{(ACC_W-IN_W){x_in[IN_W-1]}}, x_in};

    always_comb begin
        phase_d  = phase_q;
        strobe_d = 1'b0;
        if (in_valid) begin
            if (phase_q == PH_W'(RATE-1)) begin
                phase_d  = '0;
                strobe_d = 1'b1;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    // Running sum gives each stage the previous stage's new value, so the
    // last stage already includes the sample accepted on this edge.
    always_comb begin
        logic [ACC_W-1:0] run_sum;
        run_sum = x_ext;
        for (int k = 0; k < N_STAGES; k++) begin
            run_sum    = run_sum + integ_q[k];
            integ_d[k] = run_sum;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= '0;
            strobe_q <= 1'b0;
            integ_q  <= '0;
            samp_q   <= '0;
            samp_v_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
            if (in_valid) begin
                integ_q <= integ_d;
            end
            samp_v_q <= strobe_q;
            if (strobe_q) begin
                samp_q <= integ_q[N_STAGES-1];
            end
        end
    end

    logic [N_STAGES:0][ACC_W-1:0] comb_data;
    logic [N_STAGES:0]            comb_stb;

    assign comb_data[0] = samp_q;
    assign comb_stb[0]  = samp_v_q;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        cic_comb_stage #(
            .W (ACC_W),
            .M (DIFF_DELAY)
        ) u_comb (
            .clock    (clock),
            .reset    (reset),
            .data_i   (comb_data[k]),
            .strobe_i (comb_stb[k]),
            .data_o   (comb_data[k+1]),
            .strobe_o (comb_stb[k+1])
        );
    end

    logic [ACC_W-1:0] trunc_src;
    logic             trunc_v;

`ifdef CIC_DECIM_ROUND_EN
    localparam logic [ACC_W:0]   ONE_LSB = {{ACC_W{1'b0}}, 1'b1} << (ACC_W-OUT_W);
    localparam logic [ACC_W-1:0] HALF    = ONE_LSB[ACC_W:1];

    logic [ACC_W-1:0] rnd_q, rnd_d;
    logic             rnd_v_q;

    // Modular add: the positive full-scale edge wraps, as in the integrators.
    assign rnd_d = comb_data[N_STAGES] + HALF;

    always_ff @(posedge clock) begin
        if (reset) begin
            rnd_q   <= '0;
            rnd_v_q <= 1'b0;
        end else begin
            rnd_v_q <= comb_stb[N_STAGES];
            if (comb_stb[N_STAGES]) begin
                rnd_q <= rnd_d;
            end
        end
    end

    assign trunc_src = rnd_q;
    assign trunc_v   = rnd_v_q;
`else
    assign trunc_src = comb_data[N_STAGES];
    assign trunc_v   = comb_stb[N_STAGES];
`endif

    if (ACC_W > OUT_W) begin : g_lsb
        logic unused_lsbs;
        assign unused_lsbs = ^trunc_src[ACC_W-OUT_W-1:0];
    end

    logic [OUT_W-1:0] y_q, y_d;
    logic             v_q;

    assign y_d = trunc_src[ACC_W-1 -: OUT_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= trunc_v;
            if (trunc_v) begin
                y_q <= y_d;
            end
        end
    end

    assign y_out     = y_q;
    assign out_valid = v_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: full-width (OUT_W=ACC_W) and 16-bit instances
// checked against a direct-convolution model through a timed scoreboard.
module tb_cic_decimator;
    import cic_pkg::*;

    localparam int N     = 3;
    localparam int R     = 4;
    localparam int M     = 1;
    localparam int IN_W  = 16;
    localparam int ACC_W = acc_width(IN_W, N, R, M);
    localparam int LO_W  = 16;
    localparam int SH    = ACC_W - LO_W;
    localparam int HLEN  = N * (R * M - 1) + 1;
`ifdef CIC_DECIM_ROUND_EN
    localparam int LAT = N + 3;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = N + 2;
    localparam bit RND = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  x_in = '0;
    logic [ACC_W-1:0] y_hi;
    logic [LO_W-1:0]  y_lo;
    logic             v_hi, v_lo;

    always #5 clock = ~clock;

    cic_decimator #(
        .N_STAGES (N), .RATE (R), .DIFF_DELAY (M),
        .IN_W (IN_W), .OUT_W (ACC_W)
    ) u_dut_hi (
        .clock (clock), .reset (reset), .x_in (x_in),
        .in_valid (in_valid), .y_out (y_hi), .out_valid (v_hi)
    );

    cic_decimator #(
        .N_STAGES (N), .RATE (R), .DIFF_DELAY (M),
        .IN_W (IN_W), .OUT_W (LO_W)
    ) u_dut_lo (
        .clock (clock), .reset (reset), .x_in (x_in),
        .in_valid (in_valid), .y_out (y_lo), .out_valid (v_lo)
    );

    typedef struct {
        longint hi;
        longint lo;
        int     due;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint h [HLEN];
    longint hist [$];
    exp_t   sbq [$];
    longint last_hi = 0;
    longint last_lo = 0;
    logic   mon_rst;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r -= m;
        return r;
    endfunction

    function automatic void push_expect();
        exp_t   e;
        longint acc;
        int     n;
        acc = 0;
        n   = hist.size();
        for (int j = 0; j < HLEN && j < n; j++) begin
            acc += h[j] * hist[n-1-j];
        end
        e.hi = wrapw(acc, ACC_W);
        if (RND) e.lo = wrapw(e.hi + (longint'(1) << (SH - 1)), ACC_W) >>> SH;
        else     e.lo = e.hi >>> SH;
        e.due = cyc + 1 + LAT;
        sbq.push_back(e);
    endfunction

    task automatic step(input logic rst, input logic v, input longint x);
        @(negedge clock);
        reset    = rst;
        in_valid = v;
        x_in     = x[IN_W-1:0];
        if (rst) begin
            sbq.delete();
            hist.delete();
            last_hi = 0;
            last_lo = 0;
        end else if (v) begin
            hist.push_back(x);
            if (hist.size() % R == 0) push_expect();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, longint'($urandom));
    endtask

    always @(posedge clock) begin
        exp_t e;
        mon_rst = reset;
        #1;
        if (mon_rst) begin
            check("rst_y_hi", longint'($signed(y_hi)), 0);
            check("rst_y_lo", longint'($signed(y_lo)), 0);
            check("rst_valid", longint'({v_hi, v_lo}), 0);
        end else begin
            if (sbq.size() > 0 && cyc > sbq[0].due) begin
                check("late_pulse", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
            check("valid_lo_vs_hi", longint'(v_lo), longint'(v_hi));
            if (v_hi) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_cycle", cyc, e.due);
                    check("y_hi", longint'($signed(y_hi)), e.hi);
                    check("y_lo", longint'($signed(y_lo)), e.lo);
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end else begin
                check("hold_hi", longint'($signed(y_hi)), last_hi);
                check("hold_lo", longint'($signed(y_lo)), last_lo);
            end
        end
    end

    initial begin
        longint t [HLEN];
        int     len;
        foreach (h[i]) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (N) begin
            foreach (t[i]) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R * M; j++)
                    t[i+j] += h[i];
            len += R * M - 1;
            h = t;
        end

        // reset held with full-scale input present
        repeat (3) step(1'b1, 1'b1, 32'h7FFF);

        // impulse, continuous valid
        step(1'b0, 1'b1, 1);
        repeat (11) step(1'b0, 1'b1, 0);
        idle(LAT + 2);

        // impulse with gaps; junk on x_in while invalid
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, (i == 0) ? 1 : 0);
            step(1'b0, 1'b0, longint'($urandom));
            step(1'b0, 1'b0, longint'($urandom));
        end
        idle(LAT + 2);

        // DC +1
        step(1'b1, 1'b0, 0);
        repeat (24) step(1'b0, 1'b1, 1);
        idle(LAT + 2);
        check("dc_pos_hi", longint'($signed(y_hi)), 64);
        check("dc_pos_lo", longint'($signed(y_lo)), 1);

        // DC negative full scale
        step(1'b1, 1'b0, 0);
        repeat (24) step(1'b0, 1'b1, -32768);
        idle(LAT + 2);
        check("dc_negfs_hi", longint'($signed(y_hi)), -2097152);
        check("dc_negfs_lo", longint'($signed(y_lo)), -32768);

        // DC -1
        step(1'b1, 1'b0, 0);
        repeat (24) step(1'b0, 1'b1, -1);
        idle(LAT + 2);
        check("dc_m1_hi", longint'($signed(y_hi)), -64);
        check("dc_m1_lo", longint'($signed(y_lo)), -1);

        // exactly half an output LSB: 10*2 + 6*2 = 32
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 2);
        repeat (2) step(1'b0, 1'b1, 0);
        idle(LAT + 2);
        check("half_pos_hi", longint'($signed(y_hi)), 32);
        check("half_pos_lo", longint'($signed(y_lo)), RND ? 1 : 0);

        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, -2);
        step(1'b0, 1'b1, -2);
        repeat (2) step(1'b0, 1'b1, 0);
        idle(LAT + 2);
        check("half_neg_hi", longint'($signed(y_hi)), -32);
        check("half_neg_lo", longint'($signed(y_lo)), RND ? 0 : -1);

        // reset two cycles after a strobe, then a fresh impulse
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1);
        repeat (3) step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1);
        repeat (11) step(1'b0, 1'b1, 0);
        idle(LAT + 2);

        // random full-range samples with random gaps
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 9) < 7),
                 longint'($urandom_range(0, 65535)) - 32768);
        end
        idle(LAT + R + 2);

        check("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
